eth_tx_sched: RTL
=================

Name: eth_tx_sched

Overview:
- Transmit scheduler for the 10BASE-T transmit path. Runs in the 10 MHz transmit clock domain.
- Shares the single frame serializer between two frame requesters using round-robin arbitration.
- Enforces the inter-packet gap and generates normal link pulses (NLPs) while the line is idle.
- Supervises each frame with a watchdog and drives a transmit-activity indication for the LED.

Parameters:
- NLP_PERIOD, 160000, idle cycles between NLP starts (16 ms at 10 MHz).
- NLP_WIDTH, 1, NLP high time in cycles (100 ns).
- IPG_CYCLES, 96, quiet cycles after frame_done before the next grant (9.6 us).
- FRAME_TIMEOUT, 16000, maximum cycles from frame_go to frame_done (1.6 ms).
- CNT_W, 18, width of the NLP/IPG counter and of the watchdog counter; must hold NLP_PERIOD and FRAME_TIMEOUT.

Ports:
- clk  in  1  10 MHz transmit clock.
- rst_n  in  1  asynchronous active-low reset.
- link_en  in  1  1 = scheduler active; 0 = no NLPs and no new grants.
- req  in  2  frame requests; a requester holds its bit high until granted.
- gnt  out  2  one-hot grant; held from the frame_go cycle through frame completion.
- frame_go  out  1  one-cycle start strobe to the frame serializer.
- frame_done  in  1  one-cycle pulse from the serializer at the end of the TP_IDL tail.
- nlp_tx  out  1  link pulse to the line driver mux.
- tx_active  out  1  high during GO, BUSY and IPG (LED source).
- timeout_err  out  1  one-cycle pulse when the watchdog expires.

Behaviour:
- Reset (asynchronous): state IDLE; gnt=0, frame_go=0, nlp_tx=0, tx_active=0, timeout_err=0; all counters 0; round-robin pointer set so that req[0] wins first.
- States: IDLE, GO, BUSY, IPG, NLP.
- Idle counter (icnt):
  - Increments by 1 each cycle in IDLE and IPG, saturating at NLP_PERIOD-1.
  - Cleared on entering GO and on leaving NLP.
- IDLE:
  - If link_en=0: stay in IDLE; icnt holds at 0.
  - Else if icnt==NLP_PERIOD-1: go to NLP. NLP wins over any simultaneous req.
  - Else if any req bit is set: go to GO with a single winner.
    - Only one bit set: that requester wins.
    - Both bits set: the requester not granted last wins.
    - The round-robin pointer updates on each grant.
- GO (1 cycle): frame_go=1, gnt=winner, watchdog cleared. Next state BUSY.
- BUSY:
  - gnt held. Changes on req are ignored. Watchdog increments each cycle.
  - frame_done=1: gnt cleared on the next edge; go to IPG; IPG counter cleared.
  - Watchdog reaches FRAME_TIMEOUT-1 without frame_done: one-cycle timeout_err, gnt cleared, go to IPG.
  - frame_done and timeout in the same cycle: frame_done wins; no timeout_err.
- IPG:
  - Hold for IPG_CYCLES cycles, then go to IDLE.
  - frame_done seen outside BUSY is ignored everywhere.
- NLP:
  - nlp_tx=1 for NLP_WIDTH cycles, then return to IDLE with icnt=0.
  - Requests arriving during NLP wait.
- link_en deassert:
  - During BUSY or IPG: the current frame and its gap complete normally.
  - During NLP: the pulse completes.
  - In IDLE, link_en=0 blocks both NLPs and grants.
- Output timing: frame_go, gnt, nlp_tx and tx_active are registered outputs. No combinational path from req to gnt.
- Mid-frame reset: all outputs drop asynchronously. After reset release, the first action is either a grant to req[0] or the first NLP after NLP_PERIOD cycles.

Test Plan:
All scenarios use NLP_PERIOD=100, NLP_WIDTH=1, IPG_CYCLES=8, FRAME_TIMEOUT=50.
- Idle link: link_en=1, no req, 350 cycles -> nlp_tx pulses exactly 1 cycle wide, rising edges 101 cycles apart (100 counting cycles + 1 pulse cycle), first edge 100 cycles after reset release.
- Single request: req=01, frame_done 20 cycles after frame_go -> frame_go 1 cycle after req; gnt=01 for 21 cycles; next grant no earlier than 8 cycles after frame_done; icnt restarts, so no NLP for 100 idle cycles after IPG.
- Contention: req=11 held continuously, each frame done after 10 cycles -> grant sequence 01, 10, 01, 10; each pair of frames separated by exactly 8 IPG cycles.
- NLP vs request tie: req[1] asserted in the same cycle that icnt reaches 99 -> nlp_tx for 1 cycle first, then frame_go on the following IDLE cycle with gnt=10.
- Watchdog: req=01, frame_done never asserted -> timeout_err pulse 50 cycles after frame_go, gnt=00, IPG of 8 cycles, then a re-grant if req is still high; frame_done and timeout coincident -> no timeout_err.
- Reset and enable: rst_n low mid-BUSY -> gnt=00, tx_active=0 immediately. link_en=0 for 300 cycles -> no nlp_tx, no frame_go despite req=11.

Source files
------------

// File: rtl/eth_tx_sched_if.sv
// Requester/serializer handshake bundle for the 10BASE-T transmit scheduler.
// master: the scheduler; slave: the requesters and the frame serializer.
interface eth_tx_sched_if;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       frame_go;
    logic       frame_done;

    modport master (
        input  req,
        input  frame_done,
        output gnt,
        output frame_go
    );

    modport slave (
        output req,
        output frame_done,
        input  gnt,
        input  frame_go
    );
endinterface

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: shares one frame serializer between two requesters with
// round-robin arbitration, enforces the inter-packet gap, emits normal link
// pulses while idle, supervises each frame with a watchdog and drives the
// transmit-activity indication. All outputs are registered.
module eth_tx_sched #(
    parameter int unsigned NLP_PERIOD    = 160000,
    parameter int unsigned NLP_WIDTH     = 1,
    parameter int unsigned IPG_CYCLES    = 96,
    parameter int unsigned FRAME_TIMEOUT = 16000,
    parameter int unsigned CNT_W         = 18
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           link_en,
    eth_tx_sched_if.master bus,
    output logic           nlp_tx,
    output logic           tx_active,
    output logic           timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GO   = 3'd1,
        ST_BUSY = 3'd2,
        ST_IPG  = 3'd3,
        ST_NLP  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ZERO      = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] NLP_LAST  = CNT_W'(NLP_PERIOD - 1);
    localparam logic [CNT_W-1:0] NLPW_LAST = CNT_W'(NLP_WIDTH - 1);
    localparam logic [CNT_W-1:0] IPG_LAST  = CNT_W'(IPG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(FRAME_TIMEOUT - 1);

    // The idle counter never runs past the NLP threshold.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == NLP_LAST) begin
            r = v;
        end else begin
            r = v + ONE;
        end
        return r;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] icnt_r, icnt_s;    // idle / gap counter
    logic [CNT_W-1:0] wcnt_r, wcnt_s;    // frame watchdog, also times the link pulse
    logic             last_r, last_s;    // index of the requester granted last
    logic             win_s;
    logic [1:0]       gnt_r, gnt_s;
    logic             terr_s;
    logic             frame_go_r;
    logic             nlp_r;
    logic             active_r;
    logic             terr_r;

    // Round-robin winner: a lone request wins, on contention the one not served last wins.
    always_comb begin
        if (bus.req == 2'b11) begin
            win_s = ~last_r;
        end else if (bus.req[1]) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Next-state and counter logic of the scheduler FSM.
    always_comb begin
        state_s = state_r;
        icnt_s  = icnt_r;
        wcnt_s  = wcnt_r;
        last_s  = last_r;
        gnt_s   = gnt_r;
        terr_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!link_en) begin
                    icnt_s = ZERO;
                end else if (icnt_r == NLP_LAST) begin
                    // a due link pulse takes priority over any waiting request
                    state_s = ST_NLP;
                    wcnt_s  = ZERO;
                end else if (bus.req != 2'b00) begin
                    state_s = ST_GO;
                    icnt_s  = ZERO;
                    wcnt_s  = ZERO;
                    last_s  = win_s;
                    gnt_s   = win_s ? 2'b10 : 2'b01;
                end else begin
                    icnt_s = sat_inc(icnt_r);
                end
            end
            ST_GO: begin
                state_s = ST_BUSY;
                wcnt_s  = wcnt_r + ONE;
            end
            ST_BUSY: begin
                if (bus.frame_done) begin
                    state_s = ST_IPG;
                    gnt_s   = 2'b00;
                    icnt_s  = ZERO;
                end else if (wcnt_r == TO_LAST) begin
                    state_s = ST_IPG;
                    gnt_s   = 2'b00;
                    icnt_s  = ZERO;
                    terr_s  = 1'b1;
                end else begin
                    wcnt_s = wcnt_r + ONE;
                end
            end
            ST_IPG: begin
                if (icnt_r == IPG_LAST) begin
                    // restart the idle count so a full NLP period follows the gap
                    state_s = ST_IDLE;
                    icnt_s  = ZERO;
                end else begin
                    icnt_s = sat_inc(icnt_r);
                end
            end
            ST_NLP: begin
                if (wcnt_r == NLPW_LAST) begin
                    state_s = ST_IDLE;
                    icnt_s  = ZERO;
                    wcnt_s  = ZERO;
                end else begin
                    wcnt_s = wcnt_r + ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                icnt_s  = ZERO;
                wcnt_s  = ZERO;
                gnt_s   = 2'b00;
            end
        endcase
    end

    // State, counters and registered outputs; outputs decode the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            icnt_r     <= ZERO;
            wcnt_r     <= ZERO;
            last_r     <= 1'b1;
            gnt_r      <= 2'b00;
            frame_go_r <= 1'b0;
            nlp_r      <= 1'b0;
            active_r   <= 1'b0;
            terr_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            icnt_r     <= icnt_s;
            wcnt_r     <= wcnt_s;
            last_r     <= last_s;
            gnt_r      <= gnt_s;
            frame_go_r <= (state_s == ST_GO);
            nlp_r      <= (state_s == ST_NLP);
            active_r   <= (state_s == ST_GO) || (state_s == ST_BUSY) || (state_s == ST_IPG);
            terr_r     <= terr_s;
        end
    end

    assign bus.gnt      = gnt_r;
    assign bus.frame_go = frame_go_r;
    assign nlp_tx       = nlp_r;
    assign tx_active    = active_r;
    assign timeout_err  = terr_r;

endmodule
